mips_pipe_ctrl: RTL
===================

MIPS_PIPE_CTRL -- requirements
Module: mips_pipe_ctrl

Interface
REQ-001 SHALL have parameters: NB_DATA 32, datapath word width; NB_REG 5, register index width; NB_CNT 32, cycle-counter width.
REQ-002 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  run enable; pipeline frozen when 0.
- i_mode_step  in  1  1 = debug single-step mode.
- i_step  in  1  one-cycle pulse; advances pipeline one cycle in step mode.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_rs, i_id_rt, i_id_rd  in  NB_REG  ID source and destination indices.
- i_id_use_rs, i_id_use_rt  in  1  ID instruction reads rs / rt.
- i_id_reg_write, i_id_mem_read, i_id_halt  in  1  ID control: writes register, is load, is HALT.
- i_ex_branch_taken  in  1  EX resolved a taken branch/jump.
- i_ex_alu_result  in  NB_DATA  EX ALU output.
- i_mem_read_data  in  NB_DATA  data-memory read word.
- o_pc_write, o_ifid_write  out  1  PC and IF/ID load enables.
- o_ifid_flush  out  1  clear IF/ID.
- o_fwd_a, o_fwd_b  out  2  ALU operand source: 00 reg file, 01 EX/MEM, 10 MEM/WB.
- o_exmem_alu  out  NB_DATA  EX/MEM ALU result, forwarding source.
- o_wb_reg_write  out  1  register-file write strobe.
- o_wb_addr  out  NB_REG  write index.
- o_wb_data  out  NB_DATA  write data.
- o_halted  out  1  HALT retired.
- o_cycle_count  out  NB_CNT  count of advanced cycles.

Function
REQ-003 SHALL hold three control registers, ID/EX, EX/MEM and MEM/WB, each with valid, rd, reg_write, mem_read and halt; EX/MEM adds alu result; MEM/WB adds wb data: mem data if mem_read, else alu.
REQ-004 SHALL define adv = i_enable & state==RUN & (~i_mode_step | i_step); registers update only when adv.
REQ-005 SHALL run FSM RUN -> HALT when a valid halt enters MEM/WB; HALT is sticky until reset; o_halted = (state==HALT).
REQ-006 SHALL flag load-use when ID/EX is a valid load, rd != 0, and rd equals a used ID source.
REQ-007 SHALL handle load-use by driving o_pc_write=0 and o_ifid_write=0 and loading a bubble (valid=0) into ID/EX for exactly one advanced cycle.
REQ-008 SHALL handle i_ex_branch_taken by asserting o_ifid_flush and loading a bubble into ID/EX; branch overrides a simultaneous load-use, and o_pc_write stays 1.
REQ-009 SHALL compute forwarding combinationally.
- Select 01 if EX/MEM is valid with reg_write, rd != 0 and rd == source.
- Else select 10 on the same test against MEM/WB.
- Else select 00.
- Register 0 never forwards.
REQ-010 SHALL drive o_wb_* from MEM/WB; o_wb_reg_write = valid & reg_write & rd != 0 & adv.
REQ-011 SHALL force o_pc_write and o_ifid_write to 0 when adv=0.
REQ-012 SHALL increment o_cycle_count on each adv, wrapping modulo 2^NB_CNT.
REQ-013 SHALL give a valid instruction ID-to-WB latency of 3 advanced cycles.

Reset
REQ-014 SHALL on i_reset=0 asynchronously do all of the following.
- Clear all valid bits, indices and data.
- Set state to RUN and o_cycle_count to 0.
- Outputs: o_fwd_* 00, o_wb_* 0, o_halted 0, o_ifid_flush 0.
REQ-015 SHALL discard in-flight instructions on reset mid-operation, with no write strobe.

Configuration
REQ-016 SHALL compile forwarding only under MIPS_PIPE_FWD_EN.
- Defined: REQ-009 applies.
- Undefined: o_fwd_a/b are tied to 00. Any RAW against a valid writing ID/EX or EX/MEM entry stalls per REQ-007, and reg file write-first covers MEM/WB.

Structure
REQ-017 SHALL take the fwd select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and FSM state codes from package mips_pkg.
REQ-018 SHALL isolate hazard and forwarding logic in sub-module mips_hazard_unit (combinational); pipeline registers, FSM and counter stay in mips_pipe_ctrl.

Verification
REQ-019 Bench SHALL cover these scenarios.
- ALU RAW: ID/EX writes r3, next ID reads r3 as rs -> o_fwd_a=01 next cycle. Without macro -> 2 stall cycles, o_fwd_a=00.
- Load-use: load r5 in ID/EX, ID uses rt=r5 -> one cycle with o_pc_write=0 and a bubble, then o_fwd_b=10.
- Branch and load-use in the same cycle -> o_ifid_flush=1, o_pc_write=1, ID/EX bubble, no stall.
- r0 destination with reg_write -> o_fwd stays 00, o_wb_reg_write=0.
- Step mode: i_mode_step=1, 3 i_step pulses over 10 cycles -> o_cycle_count=3. HALT issued -> o_halted after 3 advances; further i_step is ignored.
- Reset asserted with a valid write in MEM/WB -> o_wb_reg_write=0 immediately, count 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the pipeline controller: forwarding selects and
// FSM state codes.
package mips_pkg;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Controller FSM state codes
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Priority pick of a forwarding source: the younger EX/MEM result wins
  function automatic logic [1:0] fwd_pick(input logic hit_exmem, input logic hit_memwb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (hit_exmem) begin
      sel = FWD_EXMEM;
    end else if (hit_memwb) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Combinational hazard detection and operand forwarding.
// Build option: MIPS_PIPE_FWD_EN enables forwarding; without it every RAW
// against an in-flight writer in ID/EX or EX/MEM stalls instead.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int NB_REG = 5
) (
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic              i_idex_valid,
  input  logic [NB_REG-1:0] i_idex_rs,
  input  logic [NB_REG-1:0] i_idex_rt,
  input  logic [NB_REG-1:0] i_idex_rd,
  input  logic              i_idex_reg_write,
  input  logic              i_idex_mem_read,
  input  logic              i_exmem_valid,
  input  logic [NB_REG-1:0] i_exmem_rd,
  input  logic              i_exmem_reg_write,
  input  logic              i_memwb_valid,
  input  logic [NB_REG-1:0] i_memwb_rd,
  input  logic              i_memwb_reg_write,
  input  logic              i_ex_branch_taken,
  output logic              o_bubble,
  output logic              o_hold,
  output logic              o_flush,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);

  logic idex_wr;
  logic exmem_wr;
  logic memwb_wr;
  logic idex_hits_id;
  logic exmem_hits_id;
  logic load_use;
  logic raw_stall;
  logic stall;

  // Which stages hold an instruction that will really write a register
  always_comb begin
    idex_wr  = i_idex_valid  & i_idex_reg_write  & (i_idex_rd  != '0);
    exmem_wr = i_exmem_valid & i_exmem_reg_write & (i_exmem_rd != '0);
    memwb_wr = i_memwb_valid & i_memwb_reg_write & (i_memwb_rd != '0);
  end

  // Source-match of the instruction sitting in ID against later stages
  always_comb begin
    idex_hits_id  = (i_id_use_rs & (i_idex_rd == i_id_rs)) |
                    (i_id_use_rt & (i_idex_rd == i_id_rt));
    exmem_hits_id = (i_id_use_rs & (i_exmem_rd == i_id_rs)) |
                    (i_id_use_rt & (i_exmem_rd == i_id_rt));
    load_use      = i_idex_valid & i_idex_mem_read & (i_idex_rd != '0) & idex_hits_id;
  end

`ifdef MIPS_PIPE_FWD_EN
  // Forward to the EX operands from EX/MEM first, then MEM/WB
  always_comb begin
    raw_stall = 1'b0;
    o_fwd_a   = fwd_pick(exmem_wr & (i_exmem_rd == i_idex_rs),
                         memwb_wr & (i_memwb_rd == i_idex_rs));
    o_fwd_b   = fwd_pick(exmem_wr & (i_exmem_rd == i_idex_rt),
                         memwb_wr & (i_memwb_rd == i_idex_rt));
  end
`else
  logic unused_fwd_srcs;

  // No bypass paths: wait until the producer reaches MEM/WB (write-first RF)
  always_comb begin
    raw_stall       = (idex_wr & idex_hits_id) | (exmem_wr & exmem_hits_id);
    o_fwd_a         = FWD_RF;
    o_fwd_b         = FWD_RF;
    unused_fwd_srcs = ^{i_idex_rs, i_idex_rt, memwb_wr};
  end
`endif

  // A taken branch squashes ID and overrides any stall request
  always_comb begin
    stall    = load_use | raw_stall;
    o_flush  = i_ex_branch_taken;
    o_bubble = i_ex_branch_taken | stall;
    o_hold   = stall & ~i_ex_branch_taken;
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline control for a 5-stage MIPS: ID/EX, EX/MEM, MEM/WB control
// registers, run/halt FSM, advanced-cycle counter and step-mode gating.
// Build option: MIPS_PIPE_FWD_EN selects forwarding over RAW stalling
// inside mips_hazard_unit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | pipeline advances when enabled (and stepped in step mode)
// ST_HALT | a HALT retired into MEM/WB; frozen until reset
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_mode_step,
  input  logic               i_step,
  input  logic               i_id_valid,
  input  logic [NB_REG-1:0]  i_id_rs,
  input  logic [NB_REG-1:0]  i_id_rt,
  input  logic [NB_REG-1:0]  i_id_rd,
  input  logic               i_id_use_rs,
  input  logic               i_id_use_rt,
  input  logic               i_id_reg_write,
  input  logic               i_id_mem_read,
  input  logic               i_id_halt,
  input  logic               i_ex_branch_taken,
  input  logic [NB_DATA-1:0] i_ex_alu_result,
  input  logic [NB_DATA-1:0] i_mem_read_data,
  output logic               o_pc_write,
  output logic               o_ifid_write,
  output logic               o_ifid_flush,
  output logic [1:0]         o_fwd_a,
  output logic [1:0]         o_fwd_b,
  output logic [NB_DATA-1:0] o_exmem_alu,
  output logic               o_wb_reg_write,
  output logic [NB_REG-1:0]  o_wb_addr,
  output logic [NB_DATA-1:0] o_wb_data,
  output logic               o_halted,
  output logic [NB_CNT-1:0]  o_cycle_count
);

  logic [0:0]         state_q,           state_d;
  logic [NB_CNT-1:0]  cnt_q,             cnt_d;

  logic               idex_valid_q,      idex_valid_d;
  logic [NB_REG-1:0]  idex_rs_q,         idex_rs_d;
  logic [NB_REG-1:0]  idex_rt_q,         idex_rt_d;
  logic [NB_REG-1:0]  idex_rd_q,         idex_rd_d;
  logic               idex_reg_write_q,  idex_reg_write_d;
  logic               idex_mem_read_q,   idex_mem_read_d;
  logic               idex_halt_q,       idex_halt_d;

  logic               exmem_valid_q,     exmem_valid_d;
  logic [NB_REG-1:0]  exmem_rd_q,        exmem_rd_d;
  logic               exmem_reg_write_q, exmem_reg_write_d;
  logic               exmem_mem_read_q,  exmem_mem_read_d;
  logic               exmem_halt_q,      exmem_halt_d;
  logic [NB_DATA-1:0] exmem_alu_q,       exmem_alu_d;

  logic               memwb_valid_q,     memwb_valid_d;
  logic [NB_REG-1:0]  memwb_rd_q,        memwb_rd_d;
  logic               memwb_reg_write_q, memwb_reg_write_d;
  logic               memwb_mem_read_q,  memwb_mem_read_d;
  logic               memwb_halt_q,      memwb_halt_d;
  logic [NB_DATA-1:0] memwb_data_q,      memwb_data_d;

  logic adv;
  logic bubble;
  logic hold;
  logic flush;
  logic unused_memwb;

  mips_hazard_unit #(
    .NB_REG (NB_REG)
  ) u_hazard (
    .i_id_rs           (i_id_rs),
    .i_id_rt           (i_id_rt),
    .i_id_use_rs       (i_id_use_rs),
    .i_id_use_rt       (i_id_use_rt),
    .i_idex_valid      (idex_valid_q),
    .i_idex_rs         (idex_rs_q),
    .i_idex_rt         (idex_rt_q),
    .i_idex_rd         (idex_rd_q),
    .i_idex_reg_write  (idex_reg_write_q),
    .i_idex_mem_read   (idex_mem_read_q),
    .i_exmem_valid     (exmem_valid_q),
    .i_exmem_rd        (exmem_rd_q),
    .i_exmem_reg_write (exmem_reg_write_q),
    .i_memwb_valid     (memwb_valid_q),
    .i_memwb_rd        (memwb_rd_q),
    .i_memwb_reg_write (memwb_reg_write_q),
    .i_ex_branch_taken (i_ex_branch_taken),
    .o_bubble          (bubble),
    .o_hold            (hold),
    .o_flush           (flush),
    .o_fwd_a           (o_fwd_a),
    .o_fwd_b           (o_fwd_b)
  );

  // Pipeline advance qualifier and front-end enables
  always_comb begin
    adv            = i_enable & (state_q == ST_RUN) & (~i_mode_step | i_step);
    o_pc_write     = adv & ~hold;
    o_ifid_write   = adv & ~hold;
    o_ifid_flush   = adv & flush;
    o_exmem_alu    = exmem_alu_q;
    o_wb_reg_write = memwb_valid_q & memwb_reg_write_q & (memwb_rd_q != '0) & adv;
    o_wb_addr      = memwb_rd_q;
    o_wb_data      = memwb_data_q;
    o_halted       = (state_q == ST_HALT);
    o_cycle_count  = cnt_q;
    unused_memwb   = ^{memwb_mem_read_q, memwb_halt_q};
  end

  // Next-state for pipeline registers, FSM and counter
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    idex_valid_d      = idex_valid_q;
    idex_rs_d         = idex_rs_q;
    idex_rt_d         = idex_rt_q;
    idex_rd_d         = idex_rd_q;
    idex_reg_write_d  = idex_reg_write_q;
    idex_mem_read_d   = idex_mem_read_q;
    idex_halt_d       = idex_halt_q;
    exmem_valid_d     = exmem_valid_q;
    exmem_rd_d        = exmem_rd_q;
    exmem_reg_write_d = exmem_reg_write_q;
    exmem_mem_read_d  = exmem_mem_read_q;
    exmem_halt_d      = exmem_halt_q;
    exmem_alu_d       = exmem_alu_q;
    memwb_valid_d     = memwb_valid_q;
    memwb_rd_d        = memwb_rd_q;
    memwb_reg_write_d = memwb_reg_write_q;
    memwb_mem_read_d  = memwb_mem_read_q;
    memwb_halt_d      = memwb_halt_q;
    memwb_data_d      = memwb_data_q;
    if (adv) begin
      cnt_d = cnt_q + NB_CNT'(1);
      if (bubble) begin
        idex_valid_d     = 1'b0;
        idex_rs_d        = '0;
        idex_rt_d        = '0;
        idex_rd_d        = '0;
        idex_reg_write_d = 1'b0;
        idex_mem_read_d  = 1'b0;
        idex_halt_d      = 1'b0;
      end else begin
        idex_valid_d     = i_id_valid;
        idex_rs_d        = i_id_rs;
        idex_rt_d        = i_id_rt;
        idex_rd_d        = i_id_rd;
        idex_reg_write_d = i_id_reg_write;
        idex_mem_read_d  = i_id_mem_read;
        idex_halt_d      = i_id_halt;
      end
      exmem_valid_d     = idex_valid_q;
      exmem_rd_d        = idex_rd_q;
      exmem_reg_write_d = idex_reg_write_q;
      exmem_mem_read_d  = idex_mem_read_q;
      exmem_halt_d      = idex_halt_q;
      exmem_alu_d       = i_ex_alu_result;
      memwb_valid_d     = exmem_valid_q;
      memwb_rd_d        = exmem_rd_q;
      memwb_reg_write_d = exmem_reg_write_q;
      memwb_mem_read_d  = exmem_mem_read_q;
      memwb_halt_d      = exmem_halt_q;
      memwb_data_d      = exmem_mem_read_q ? i_mem_read_data : exmem_alu_q;
      if (exmem_valid_q & exmem_halt_q) begin
        state_d = ST_HALT;
      end
    end
  end

  // State registers, cleared asynchronously so reset drops in-flight work
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q           <= ST_RUN;
      cnt_q             <= '0;
      idex_valid_q      <= 1'b0;
      idex_rs_q         <= '0;
      idex_rt_q         <= '0;
      idex_rd_q         <= '0;
      idex_reg_write_q  <= 1'b0;
      idex_mem_read_q   <= 1'b0;
      idex_halt_q       <= 1'b0;
      exmem_valid_q     <= 1'b0;
      exmem_rd_q        <= '0;
      exmem_reg_write_q <= 1'b0;
      exmem_mem_read_q  <= 1'b0;
      exmem_halt_q      <= 1'b0;
      exmem_alu_q       <= '0;
      memwb_valid_q     <= 1'b0;
      memwb_rd_q        <= '0;
      memwb_reg_write_q <= 1'b0;
      memwb_mem_read_q  <= 1'b0;
      memwb_halt_q      <= 1'b0;
      memwb_data_q      <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      idex_valid_q      <= idex_valid_d;
      idex_rs_q         <= idex_rs_d;
      idex_rt_q         <= idex_rt_d;
      idex_rd_q         <= idex_rd_d;
      idex_reg_write_q  <= idex_reg_write_d;
      idex_mem_read_q   <= idex_mem_read_d;
      idex_halt_q       <= idex_halt_d;
      exmem_valid_q     <= exmem_valid_d;
      exmem_rd_q        <= exmem_rd_d;
      exmem_reg_write_q <= exmem_reg_write_d;
      exmem_mem_read_q  <= exmem_mem_read_d;
      exmem_halt_q      <= exmem_halt_d;
      exmem_alu_q       <= exmem_alu_d;
      memwb_valid_q     <= memwb_valid_d;
      memwb_rd_q        <= memwb_rd_d;
      memwb_reg_write_q <= memwb_reg_write_d;
      memwb_mem_read_q  <= memwb_mem_read_d;
      memwb_halt_q      <= memwb_halt_d;
      memwb_data_q      <= memwb_data_d;
    end
  end

endmodule
